// File: rtl/synapse_bank.sv
// -----------------------------------------------------------------------------
// synapse_bank
//   Bank of N competitive-learning synapses feeding one postsynaptic neuron.
//   Each synapse starts from a random seed weight and becomes a candidate when
//   its presynaptic input fires. If the neuron fires during learning, it
//   commits to STORE1 (candidate) or STORE0 (idle). A burst on post_in freezes
//   a committed synapse (HOLD) until learning is released.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst_n        asynchronous active-low reset
//   learn        learning enable
//   clear        synchronous clear of all learning state (priority below rst_n)
//   pre[N]       presynaptic spikes
//   rand_w[N]    random seed bit per synapse
//   post_in      postsynaptic spike (asynchronous, synchronised internally)
//   weight_up    pre & registered up request
//   weight_down  pre & registered down request
//   weight_sum   registered sum of weights of the active inputs
//   locked_cnt   registered count of synapses in STORE0/STORE1/HOLD0/HOLD1
// -----------------------------------------------------------------------------
module synapse_bank #(
   parameter  int N         = 8,
   parameter  int WW        = 4,
   parameter  int STEP      = 1,
   parameter  int POST_HOLD = 2,
   localparam int CW        = $clog2(N + 1),
   localparam int SW        = WW + CW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          learn,
   input  logic          clear,
   input  logic [N-1:0]  pre,
   input  logic [N-1:0]  rand_w,
   input  logic          post_in,
   output logic [N-1:0]  weight_up,
   output logic [N-1:0]  weight_down,
   output logic [SW-1:0] weight_sum,
   output logic [CW-1:0] locked_cnt
);

   localparam int PCW = $clog2(POST_HOLD + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CAND,
      S_STORE0,
      S_STORE1,
      S_HOLD0,
      S_HOLD1
   } syn_state_e;

   syn_state_e      state_q [N];
   logic [WW-1:0]   w_q     [N];
   logic [WW-1:0]   w_d     [N];
   logic [WW:0]     inc_w   [N];
   logic [N-1:0]    up_q, up_d;
   logic [N-1:0]    down_q, down_d;
   logic            post_s1_q, post_s2_q;
   logic [PCW-1:0]  pc_q;
   logic [SW-1:0]   sum_q, sum_d;
   logic [CW-1:0]   lock_q, lock_d;
   logic            burst;
   logic            learn_post;

   assign burst      = (pc_q == PCW'(POST_HOLD));
   assign learn_post = learn & post_s2_q;

   // Datapath values registered from the current state.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can
      // leave one unassigned and infer a latch.
      up_d   = '0;
      down_d = '0;
      sum_d  = '0;
      lock_d = '0;
      for (int i = 0; i < N; i++) begin
         w_d[i]   = w_q[i];
         // One extra bit so an increment past WMAX is seen, not wrapped.
         inc_w[i] = {1'b0, w_q[i]} + (WW + 1)'(STEP);
         case (state_q[i])
            S_IDLE, S_CAND: begin
               up_d[i] = rand_w[i];
               w_d[i]  = rand_w[i] ? (WW'(1) << (WW - 1)) : '0;
            end
            S_STORE0: begin
               down_d[i] = 1'b1;
               w_d[i]    = (w_q[i] > WW'(STEP)) ? (w_q[i] - WW'(STEP)) : '0;
            end
            S_STORE1: begin
               up_d[i] = 1'b1;
               w_d[i]  = inc_w[i][WW] ? '1 : inc_w[i][WW-1:0];
            end
            default: ;
         endcase
         if (pre[i]) sum_d = sum_d + SW'(w_q[i]);
         if (state_q[i] inside {S_STORE0, S_STORE1, S_HOLD0, S_HOLD1})
            lock_d = lock_d + CW'(1);
      end
   end

   // NOTE: all sequential state uses non-blocking assignments so every
   // register samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         post_s1_q <= 1'b0;
         post_s2_q <= 1'b0;
         pc_q      <= '0;
         up_q      <= '0;
         down_q    <= '0;
         sum_q     <= '0;
         lock_q    <= '0;
         // NOTE: the weight array is a handful of flops, not a RAM macro, and
         // its reset value is observable, so it is reset like any register.
         for (int i = 0; i < N; i++) begin
            state_q[i] <= S_IDLE;
            w_q[i]     <= '0;
         end
      end else if (clear) begin
         post_s1_q <= 1'b0;
         post_s2_q <= 1'b0;
         pc_q      <= '0;
         up_q      <= '0;
         down_q    <= '0;
         sum_q     <= '0;
         lock_q    <= '0;
         for (int i = 0; i < N; i++) begin
            state_q[i] <= S_IDLE;
            w_q[i]     <= '0;
         end
      end else begin
         post_s1_q <= post_in;
         post_s2_q <= post_s1_q;
         // Burst counter runs on raw post_in; any low cycle restarts it.
         if (!post_in)   pc_q <= '0;
         else if (!burst) pc_q <= pc_q + PCW'(1);
         up_q   <= up_d;
         down_q <= down_d;
         sum_q  <= sum_d;
         lock_q <= lock_d;
         for (int i = 0; i < N; i++) begin
            w_q[i] <= w_d[i];
            case (state_q[i])
               // Post wins over a simultaneous pre spike.
               S_IDLE:   if (learn_post)       state_q[i] <= S_STORE0;
                         else if (pre[i])      state_q[i] <= S_CAND;
               S_CAND:   if (learn_post)       state_q[i] <= S_STORE1;
                         else if (!learn)      state_q[i] <= S_IDLE;
               S_STORE0: if (learn && burst)   state_q[i] <= S_HOLD0;
               S_STORE1: if (learn && burst)   state_q[i] <= S_HOLD1;
               S_HOLD0:  if (!learn)           state_q[i] <= S_STORE0;
               S_HOLD1:  if (!learn)           state_q[i] <= S_STORE1;
               default:                        state_q[i] <= S_IDLE;
            endcase
         end
      end
   end

   assign weight_up   = pre & up_q;
   assign weight_down = pre & down_q;
   assign weight_sum  = sum_q;
   assign locked_cnt  = lock_q;

endmodule

// File: doc/synapse_bank.md
# synapse_bank

Parametrised bank of N learning synapses feeding one postsynaptic neuron, with multi-bit saturating weights. Each synapse runs its own competitive-learning state machine: it starts randomised, becomes a candidate when its presynaptic input fires, commits to a stored 0 or 1 when the neuron fires during learning, and freezes on a post burst. The bank drives per-synapse up/down pulses and a registered weighted sum of the active inputs for the neuron integrator.

## Interface
- N, 8: number of synapses (≥1).
- WW, 4: weight width in bits; WMAX = 2^WW−1.
- STEP, 1: weight increment/decrement per cycle (1..WMAX).
- POST_HOLD, 2: consecutive post_in-high cycles that form a burst (≥1).
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- learn  in  1  learning enable.
- clear  in  1  synchronous clear of all learning state; priority over everything except rst_n.
- pre  in  N  presynaptic spikes, one bit per synapse.
- rand_w  in  N  random seed bit per synapse.
- post_in  in  1  postsynaptic spike, asynchronous to pattern timing.
- weight_up  out  N  pre[i] & up_r[i], combinational gate of a registered bit.
- weight_down  out  N  pre[i] & down_r[i].
- weight_sum  out  WW+clog2(N+1)  registered sum of w[i] over active pre[i].
- locked_cnt  out  clog2(N+1)  registered count of synapses in STORE0/STORE1/HOLD0/HOLD1.

## Operation
- post_in passes through a 2-flop synchroniser (post_s1, post_s2); post_s2 drives transitions.
- Burst counter pc: increments on each edge with raw post_in=1, saturates at POST_HOLD, clears to 0 on any edge with post_in=0. burst = (pc==POST_HOLD).
- Per-synapse states, priority top-down within each state:
  - IDLE: learn&post_s2 → STORE0; pre[i] → CAND; else IDLE.
  - CAND: learn&post_s2 → STORE1; !learn → IDLE; else CAND.
  - STORE0: learn&burst → HOLD0; else STORE0.
  - STORE1: learn&burst → HOLD1; else STORE1.
  - HOLD0: !learn → STORE0. HOLD1: !learn → STORE1.
- Simultaneous pre[i] and learn&post_s2 in IDLE: post wins → STORE0.
- up_r/down_r registered from current state: IDLE/CAND up=rand_w[i], down=0; STORE0 up=0, down=1; STORE1 up=1, down=0; HOLD0/HOLD1 both 0.
- Weight w[i], WW bits, registered from current state:
  - IDLE/CAND: w = rand_w[i] ? 2^(WW−1) : 0.
  - STORE1: w = min(w+STEP, WMAX), computed at WW+1 bits then saturated; no wrap.
  - STORE0: w = (w>STEP) ? w−STEP : 0; no underflow.
  - HOLD0/HOLD1: w held.
- weight_sum = Σ (pre[i] ? w[i] : 0), full width, never overflows.
- clear=1: all synapses → IDLE, w, up_r, down_r, pc, post_s1/s2, weight_sum, locked_cnt ← 0.

## Timing
- Reset: all states IDLE; w, up_r, down_r, pc, post_s1, post_s2, weight_sum, locked_cnt = 0; weight_up/down = 0.
- post_in high sampled at edge k: post_s2=1 after k+1; state changes at k+2; up_r/down_r and w reflect new state at k+3.
- pre[i] at edge k (IDLE): CAND after k.
- Burst: post_in high at edges k..k+POST_HOLD−1 → burst=1 after k+POST_HOLD−1; STORE→HOLD at the next edge if learn.
- weight_sum at edge k+1 uses pre and w as sampled at edge k (1-cycle latency). locked_cnt lags state by 1 cycle.
- learn dropping in CAND: IDLE next edge; w stays at seed value.
- rst_n asserted mid-operation: immediate return to reset values regardless of clk.

## Test plan
- Reset: rst_n low with pre=all 1s, post_in=1 → all outputs 0; after release with learn=0, rand_w=4'b0101 (N=4,WW=4) and pre=4'b1111, weight_up=4'b0101 from the second edge, weight_sum=16 from the third.
- Learn: learn=1, pre=4'b0011 one cycle, then post_in=1 one cycle → syn0/1 STORE1, syn2/3 STORE0; after 16 further cycles w0=w1=15, w2=w3=0, pre=4'b1111 gives weight_sum=30, locked_cnt=4.
- Saturation, STEP=4: STORE1 from w=8 → 12, 15, 15; STORE0 from 8 → 4, 0, 0.
- Burst freeze: locked synapses, learn=1, post_in high 2 cycles → HOLD, weight_up=weight_down=0, w frozen; learn=0 → back to STORE, up/down resume next cycle.
- Simultaneous: syn in IDLE, pre[i]=1 same edge as learn&post_s2=1 → STORE0, weight_down[i]=1 when pre[i]=1.
- clear mid-learning: all STORE states → IDLE, weight_sum=0 and locked_cnt=0 after the edge; a single-cycle post_in glitch (pc=1) never causes HOLD.
